// File: rtl/sdram_responder.sv
// sdram_responder
//   Device-side model of the DE10-Lite SDRAM chip. Decodes DRAM_* commands,
//   walks the power-up init sequence, keeps the mode register, per-bank open
//   rows and the refresh interval, and serves reads/writes from an on-chip
//   backing array so a memory controller can be exercised without the part.
//
//   Optional build macro: SDRAM_RESP_TIMING_CHECK_EN adds per-bank TRCD/TRP
//   checking (violations flag protocol_err; the command still executes).
//
// Ports
//   clk            clock, commands sampled on the rising edge
//   rst            synchronous active-high reset (backing array retained)
//   DRAM_ADDR      row / column / mode address
//   DRAM_BA        bank address
//   DRAM_DQ        bidirectional data bus (Z unless read data is due)
//   DRAM_LDQM      lower byte mask
//   DRAM_UDQM      upper byte mask
//   DRAM_RAS_N     command bit
//   DRAM_CAS_N     command bit
//   DRAM_WE_N      command bit
//   DRAM_CKE       clock enable, 0 freezes all state
//   DRAM_CS_N      chip select
//   init_done      init sequence complete
//   protocol_err   sticky illegal-command flag
//   refresh_miss   sticky refresh-interval violation
module sdram_responder #(
   parameter int unsigned ROW_IDX_BITS = 4,
   parameter int unsigned COL_IDX_BITS = 6,
   parameter int unsigned REF_INTERVAL = 1024,
   parameter int unsigned TRCD         = 1,
   parameter int unsigned TRP          = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] DRAM_ADDR,
   input  logic [1:0]  DRAM_BA,
   inout  wire  [15:0] DRAM_DQ,
   input  logic        DRAM_LDQM,
   input  logic        DRAM_UDQM,
   input  logic        DRAM_RAS_N,
   input  logic        DRAM_CAS_N,
   input  logic        DRAM_WE_N,
   input  logic        DRAM_CKE,
   input  logic        DRAM_CS_N,
   output logic        init_done,
   output logic        protocol_err,
   output logic        refresh_miss
);

   localparam int unsigned IDX_W = 2 + ROW_IDX_BITS + COL_IDX_BITS;
   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned REF_W = $clog2(REF_INTERVAL + 2);
   localparam logic [REF_W-1:0] REF_LIM = REF_W'(REF_INTERVAL);

   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_ILL = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_PRE,
      ST_REF1,
      ST_REF2,
      ST_READY
   } init_e;

   typedef struct packed {
      logic        vld;
      logic        lm;
      logic        um;
      logic [15:0] data;
   } rd_slot_t;

   cmd_e                             cmd;
   init_e                            state_q, state_d;
   logic [3:0]                       open_q, open_d;
   logic [3:0][ROW_IDX_BITS-1:0]     row_q, row_d;  // only the index bits of the open row matter
   logic                             cl3_q, cl3_d;
   rd_slot_t [2:0]                   pipe_q, pipe_d;
   logic [REF_W-1:0]                 refcnt_q, refcnt_d;
   logic                             perr_q, perr_d;
   logic                             rmiss_q, rmiss_d;
   logic [15:0]                      mem [DEPTH];
   logic                             mem_we;
   logic [1:0]                       mem_be;
   logic [IDX_W-1:0]                 idx;
   rd_slot_t                         rd_slot;
   logic                             ready;
   logic                             init_adv;
   logic                             do_lmr;
   logic                             unused_addr;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam logic [7:0] RCD_LIM = 8'(TRCD);
   localparam logic [7:0] RP_LIM  = 8'(TRP);
   logic [3:0][7:0] rcd_q, rcd_d;
   logic [3:0][7:0] rp_q, rp_d;
`endif

   assign cmd = (DRAM_CKE && !DRAM_CS_N) ? cmd_e'({DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}) : CMD_NOP;
   assign idx = {DRAM_BA, row_q[DRAM_BA], DRAM_ADDR[COL_IDX_BITS-1:0]};
   assign rd_slot = {1'b1, DRAM_LDQM, DRAM_UDQM, mem[idx]};
   assign ready = (state_q == ST_READY);
   assign unused_addr = ^DRAM_ADDR;

   // ---------------- init FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_PWRUP;
      end else if (DRAM_CKE) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_PWRUP: if (cmd == CMD_PRE && DRAM_ADDR[10]) state_d = ST_PRE;
         ST_PRE:   if (cmd == CMD_REF) state_d = ST_REF1;
         ST_REF1:  if (cmd == CMD_REF) state_d = ST_REF2;
         ST_REF2:  if (cmd == CMD_LMR) state_d = ST_READY;
         default:  state_d = state_q;
      endcase
   end

   always_comb begin
      init_done = (state_q == ST_READY);
   end

   // Extra REFRESH in REF2 is an accepted command even though the state holds.
   assign init_adv = (state_d != state_q) || (state_q == ST_REF2 && cmd == CMD_REF);
   assign do_lmr   = (cmd == CMD_LMR) && ((state_q == ST_REF2) || (ready && !(|open_q)));

   // ---------------- command datapath ----------------
   always_comb begin
      open_d   = open_q;
      row_d    = row_q;
      cl3_d    = cl3_q;
      perr_d   = perr_q;
      rmiss_d  = rmiss_q;
      refcnt_d = refcnt_q;
      pipe_d   = {rd_slot_t'('0), pipe_q[2], pipe_q[1]};
      mem_we   = 1'b0;
      mem_be   = {!DRAM_UDQM, !DRAM_LDQM};
`ifdef SDRAM_RESP_TIMING_CHECK_EN
      for (int unsigned b = 0; b < 4; b++) begin
         rcd_d[b] = (rcd_q[b] < RCD_LIM) ? rcd_q[b] + 8'd1 : rcd_q[b];
         rp_d[b]  = (rp_q[b]  < RP_LIM)  ? rp_q[b]  + 8'd1 : rp_q[b];
      end
`endif
      if (!ready) begin
         if (cmd != CMD_NOP && !init_adv) perr_d = 1'b1;
      end else begin
         case (cmd)
            CMD_ACT: begin
               if (open_q[DRAM_BA]) begin
                  perr_d = 1'b1;
               end else begin
                  open_d[DRAM_BA] = 1'b1;
                  row_d[DRAM_BA]  = DRAM_ADDR[ROW_IDX_BITS-1:0];
`ifdef SDRAM_RESP_TIMING_CHECK_EN
                  if (rp_q[DRAM_BA] < RP_LIM) perr_d = 1'b1;
                  rcd_d[DRAM_BA] = 8'd1;
`endif
               end
            end
            CMD_RD, CMD_WR: begin
               if (!open_q[DRAM_BA]) begin
                  perr_d = 1'b1;
               end else begin
`ifdef SDRAM_RESP_TIMING_CHECK_EN
                  if (rcd_q[DRAM_BA] < RCD_LIM) perr_d = 1'b1;
`endif
                  if (cmd == CMD_WR) begin
                     if (pipe_q[0].vld || pipe_q[1].vld || pipe_q[2].vld) begin
                        perr_d = 1'b1;
                        pipe_d = '0;
                     end
                     mem_we = 1'b1;
                  end else if (cl3_q) begin
                     pipe_d[2] = rd_slot;
                  end else begin
                     pipe_d[1] = rd_slot;
                  end
                  if (DRAM_ADDR[10]) open_d[DRAM_BA] = 1'b0;
               end
            end
            CMD_PRE: begin
               if (DRAM_ADDR[10]) open_d = '0;
               else               open_d[DRAM_BA] = 1'b0;
            end
            CMD_REF: begin
               if (|open_q) perr_d = 1'b1;
            end
            CMD_LMR: begin
               if (|open_q) perr_d = 1'b1;
            end
            CMD_ILL: perr_d = 1'b1;
            default: ;
         endcase

         if (cmd == CMD_REF)        refcnt_d = '0;
         else if (refcnt_q != '1)   refcnt_d = refcnt_q + 1'b1;
         if (refcnt_d > REF_LIM)    rmiss_d  = 1'b1;
      end

      if (do_lmr) begin
         case (DRAM_ADDR[6:4])
            3'd2:    cl3_d = 1'b0;
            3'd3:    cl3_d = 1'b1;
            default: begin
               cl3_d  = 1'b0;
               perr_d = 1'b1;
            end
         endcase
         if (DRAM_ADDR[2:0] != 3'b000) perr_d = 1'b1;
      end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
      // Any bank that closes this edge (explicit or auto-precharge) restarts TRP.
      for (int unsigned b = 0; b < 4; b++) begin
         if (open_q[b] && !open_d[b]) rp_d[b] = 8'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         open_q   <= '0;
         row_q    <= '0;
         cl3_q    <= 1'b0;
         pipe_q   <= '0;
         refcnt_q <= '0;
         perr_q   <= 1'b0;
         rmiss_q  <= 1'b0;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
         rcd_q    <= {4{RCD_LIM}};
         rp_q     <= {4{RP_LIM}};
`endif
      end else if (DRAM_CKE) begin
         open_q   <= open_d;
         row_q    <= row_d;
         cl3_q    <= cl3_d;
         pipe_q   <= pipe_d;
         refcnt_q <= refcnt_d;
         perr_q   <= perr_d;
         rmiss_q  <= rmiss_d;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
         rcd_q    <= rcd_d;
         rp_q     <= rp_d;
`endif
      end
   end

   // Backing array has no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         if (mem_be[0]) mem[idx][7:0]  <= DRAM_DQ[7:0];
         if (mem_be[1]) mem[idx][15:8] <= DRAM_DQ[15:8];
      end
   end

   assign DRAM_DQ[7:0]  = (pipe_q[0].vld && !pipe_q[0].lm) ? pipe_q[0].data[7:0]  : 8'hzz;
   assign DRAM_DQ[15:8] = (pipe_q[0].vld && !pipe_q[0].um) ? pipe_q[0].data[15:8] : 8'hzz;
   assign protocol_err  = perr_q;
   assign refresh_miss  = rmiss_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed bench for sdram_responder. The DQ bus has pull-ups, so a
//   released (Z) byte reads back as 8'hFF.
module tb_sdram_responder;

   localparam int unsigned REF_INT = 40;

   localparam logic [2:0] C_LMR = 3'b000;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_ILL = 3'b110;
   localparam logic [2:0] C_NOP = 3'b111;

   localparam logic [15:0] BUS_Z = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] addr = '0;
   logic [1:0]  ba = '0;
   logic        ldqm = 1'b0;
   logic        udqm = 1'b0;
   logic        ras_n = 1'b1;
   logic        cas_n = 1'b1;
   logic        we_n = 1'b1;
   logic        cke = 1'b1;
   logic        cs_n = 1'b0;
   logic        dq_oe = 1'b0;
   logic [15:0] dq_drv = '0;
   wire  [15:0] dq;
   logic        init_done;
   logic        perr;
   logic        rmiss;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   assign dq = dq_oe ? dq_drv : 16'hzzzz;

   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (dq[g]);
   end

   always #5 clk = ~clk;

   sdram_responder #(
      .REF_INTERVAL(REF_INT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .DRAM_ADDR    (addr),
      .DRAM_BA      (ba),
      .DRAM_DQ      (dq),
      .DRAM_LDQM    (ldqm),
      .DRAM_UDQM    (udqm),
      .DRAM_RAS_N   (ras_n),
      .DRAM_CAS_N   (cas_n),
      .DRAM_WE_N    (we_n),
      .DRAM_CKE     (cke),
      .DRAM_CS_N    (cs_n),
      .init_done    (init_done),
      .protocol_err (perr),
      .refresh_miss (rmiss)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One command per clock; returns just after the following falling edge.
   task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d, input logic oe, input logic lm, input logic um);
      {ras_n, cas_n, we_n} = c;
      ba     = b;
      addr   = a;
      dq_drv = d;
      dq_oe  = oe;
      ldqm   = lm;
      udqm   = um;
      @(posedge clk);
      @(negedge clk);
      {ras_n, cas_n, we_n} = C_NOP;
      dq_oe = 1'b0;
      ldqm  = 1'b0;
      udqm  = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
      step(c, b, a, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic nop();
      issue(C_NOP, 2'd0, 13'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nop();
      nop();
      rst = 1'b0;
   endtask

   task automatic do_init(input logic [12:0] mode);
      issue(C_PRE, 2'd0, 13'h0400);
      nop();
      issue(C_REF, 2'd0, 13'h0000);
      nop();
      issue(C_REF, 2'd0, 13'h0000);
      nop();
      check("pre_lmr_init_done", 16'(init_done), 16'd0);
      issue(C_LMR, 2'd0, mode);
      check("post_lmr_init_done", 16'(init_done), 16'd1);
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst_init_done", 16'(init_done), 16'd0);
      check("rst_perr", 16'(perr), 16'd0);
      check("rst_rmiss", 16'(rmiss), 16'd0);
      check("rst_dq", dq, BUS_Z);

      // ACTIVE before init is rejected
      issue(C_ACT, 2'd0, 13'h0000);
      check("early_act_perr", 16'(perr), 16'd1);
      check("early_act_dq", dq, BUS_Z);
      do_reset();
      check("rst2_perr", 16'(perr), 16'd0);

      // init with CL=2, BL=1
      do_init(13'h0028);
      check("init_perr", 16'(perr), 16'd0);

      // write BEEF with auto-precharge, reopen, read with auto-precharge
      issue(C_ACT, 2'd1, 13'h0005);
      step(C_WR, 2'd1, 13'h0403, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      issue(C_ACT, 2'd1, 13'h0005);
      issue(C_RD, 2'd1, 13'h0403);
      check("rd1_edge1", dq, BUS_Z);
      nop();
      check("rd1_edge2", dq, 16'hBEEF);
      nop();
      check("rd1_edge3", dq, BUS_Z);
      check("rd1_perr", 16'(perr), 16'd0);
      // bank 1 must be closed: reopening is legal
      issue(C_ACT, 2'd1, 13'h0005);
      check("reopen_perr", 16'(perr), 16'd0);

      // LDQM keeps the old low byte
      step(C_WR, 2'd1, 13'h0403, 16'h1234, 1'b1, 1'b1, 1'b0);
      issue(C_ACT, 2'd1, 13'h0005);
      issue(C_RD, 2'd1, 13'h0403);
      nop();
      check("ldqm_rd", dq, 16'h12EF);
      nop();
      check("ldqm_rd_after", dq, BUS_Z);

      // UDQM on READ releases the high byte
      issue(C_ACT, 2'd1, 13'h0005);
      step(C_RD, 2'd1, 13'h0403, 16'h0000, 1'b0, 1'b0, 1'b1);
      nop();
      check("udqm_rd", dq, 16'hFFEF);

      // back-to-back reads
      issue(C_ACT, 2'd2, 13'h0007);
      step(C_WR, 2'd2, 13'h0000, 16'h0102, 1'b1, 1'b0, 1'b0);
      step(C_WR, 2'd2, 13'h0001, 16'h0304, 1'b1, 1'b0, 1'b0);
      issue(C_RD, 2'd2, 13'h0000);
      check("b2b_edge1", dq, BUS_Z);
      issue(C_RD, 2'd2, 13'h0401);
      check("b2b_word0", dq, 16'h0102);
      nop();
      check("b2b_word1", dq, 16'h0304);
      nop();
      check("b2b_idle", dq, BUS_Z);
      check("b2b_perr", 16'(perr), 16'd0);

      // refresh, then errors on closed banks; count restarts here
      issue(C_REF, 2'd0, 13'h0000);
      check("ref_rmiss", 16'(rmiss), 16'd0);
      issue(C_RD, 2'd0, 13'h0000);
      check("rd_closed_perr", 16'(perr), 16'd1);
      nop();
      check("rd_closed_dq1", dq, BUS_Z);
      nop();
      check("rd_closed_dq2", dq, BUS_Z);
      step(C_WR, 2'd1, 13'h0003, 16'hDEAD, 1'b1, 1'b0, 1'b0);

      // refresh interval boundary: count = REF_INT is fine, REF_INT+1 is a miss
      for (int k = 5; k <= int'(REF_INT); k++) nop();
      check("rmiss_at_limit", 16'(rmiss), 16'd0);
      nop();
      check("rmiss_past_limit", 16'(rmiss), 16'd1);
      issue(C_REF, 2'd0, 13'h0000);
      check("rmiss_sticky", 16'(rmiss), 16'd1);

      // reset the edge after a READ drops the pending word
      issue(C_ACT, 2'd1, 13'h0005);
      issue(C_RD, 2'd1, 13'h0403);
      rst = 1'b1;
      nop();
      check("rst_mid_dq", dq, BUS_Z);
      check("rst_mid_init_done", 16'(init_done), 16'd0);
      check("rst_mid_perr", 16'(perr), 16'd0);
      check("rst_mid_rmiss", 16'(rmiss), 16'd0);
      rst = 1'b0;
      nop();
      check("rst_mid_dq_after", dq, BUS_Z);

      // re-init with CL=3; data retained and unaffected by the rejected write
      do_init(13'h0030);
      issue(C_ACT, 2'd1, 13'h0005);
      issue(C_RD, 2'd1, 13'h0403);
      check("cl3_edge1", dq, BUS_Z);
      nop();
      check("cl3_edge2", dq, BUS_Z);
      nop();
      check("cl3_edge3", dq, 16'h12EF);
      nop();
      check("cl3_edge4", dq, BUS_Z);
      check("cl3_perr", 16'(perr), 16'd0);

      // illegal encoding
      issue(C_ILL, 2'd0, 13'h0000);
      check("illegal_perr", 16'(perr), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
